// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: shared state encodings, cause codes and default vectors
package pc_sequencer_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, HOLD = 2'd1, HOLD_PEND = 2'd2} state_t;
  localparam logic [4:0] ADDR_ERR = 5'd4;
  localparam logic [4:0] WDOG = 5'd13;
  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_0080;
endpackage

// File: rtl/pc_sequencer_stall_watchdog.sv
// stall_watchdog: counts consecutive stall cycles and pulses timeout on the STALL_TIMEOUT-th
module stall_watchdog #(
  parameter int STALL_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic stall,
  output logic timeout
);
  localparam int W = $clog2(STALL_TIMEOUT);
  logic [W-1:0] cnt;
  assign timeout = stall && cnt == W'(STALL_TIMEOUT - 1);
  always_ff @(posedge clk)
    cnt <= (rst || !stall || timeout) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC select with stall hold, redirect buffering, EPC/cause capture and watchdog
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR,
  parameter int STALL_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_cur,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        exc_req,
  input  logic [4:0]  exc_code,
  input  logic        eret,
  output logic [31:0] pc_next,
  output logic [31:0] epc,
  output logic [4:0]  cause,
  output logic        exc_active,
  output logic        dbl_fault,
  output logic        redir_pend
);
  state_t state, state_n;
  logic timeout, hold, go, pend, pend_exc, ext_exc, eret_go, br_sel, mis, exc_take;
  logic [4:0] pend_code, code_sel;
  logic [31:0] pend_target, tgt;
  stall_watchdog #(.STALL_TIMEOUT(STALL_TIMEOUT)) u_wdog (
    .clk(clk),
    .rst(rst),
    .stall(stall),
    .timeout(timeout)
  );
  assign pend = state == HOLD_PEND;
  assign redir_pend = pend;
  always_comb begin
    hold = stall && !timeout;
    go = !hold;
    ext_exc = timeout || (go && exc_req) || (go && pend && pend_exc);
    eret_go = go && !pend && eret && exc_active && !ext_exc;
    br_sel = go && !ext_exc && !eret_go && (pend || jump || br_taken);
    tgt = pend ? pend_target : jump ? jump_target : br_target;
    mis = br_sel && tgt[1:0] != 2'b00;
    exc_take = ext_exc || mis;
    code_sel = timeout ? WDOG : (go && exc_req) ? exc_code : (pend && pend_exc) ? pend_code : ADDR_ERR;
    pc_next = rst ? RESET_VECTOR : exc_take ? EXC_VECTOR : hold ? pc_cur :
              eret_go ? epc : br_sel ? tgt : pc_cur + 32'd4;
    state_n = hold ? ((pend || exc_req || jump || br_taken) ? HOLD_PEND : HOLD) : RUN;
  end
  always_ff @(posedge clk)
    state <= rst ? RUN : state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      epc <= '0;
      cause <= '0;
      exc_active <= 1'b0;
      dbl_fault <= 1'b0;
      pend_exc <= 1'b0;
      pend_code <= '0;
      pend_target <= '0;
    end else begin
      if (hold && exc_req && !(pend && pend_exc)) begin
        pend_exc <= 1'b1;
        pend_code <= exc_code;
      end else if (hold && (jump || br_taken) && !pend && !exc_req) begin
        pend_exc <= 1'b0;
        pend_target <= jump ? jump_target : br_target;
      end
      if (exc_take && exc_active)
        dbl_fault <= 1'b1;
      else if (exc_take) begin
        epc <= pc_cur;
        cause <= code_sel;
        exc_active <= 1'b1;
      end else if (eret_go)
        exc_active <= 1'b0;
    end
  end
endmodule
